// File: rtl/ibex_pmp_csr_regs.sv
// ---------------------------------------------------------------------------
// ibex_pmp_csr_regs
//
// Register-file side of the PMP. Holds the pmpcfg/pmpaddr state that the PMP
// checker consumes, and serves CSR read/write transactions for
// pmpcfg0-3 (0x3A0-0x3A3) and pmpaddr0-15 (0x3B0-0x3BF) over a
// req/gnt/rvalid handshake with a fixed one-cycle response latency.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   csr_req_i / csr_gnt_o  request / accept (accept = req & gnt)
//   csr_we_i               1 = write, 0 = read
//   csr_addr_i             12-bit CSR address
//   csr_wdata_i            write data
//   csr_rvalid_o           response valid, exactly one cycle after accept
//   csr_rdata_o            pre-write register value (valid with rvalid)
//   csr_err_o              illegal CSR address (valid with rvalid)
//   csr_pmp_cfg_o          per-entry config to the checker
//   csr_pmp_addr_o         per-entry address to the checker, {pmpaddr, 2'b00}
//   pmp_cfg_updated_o      pulse with rvalid when a write changed stored state
// ---------------------------------------------------------------------------

package ibex_pkg;

    typedef enum logic [1:0] {
        PMP_MODE_OFF   = 2'b00,
        PMP_MODE_TOR   = 2'b01,
        PMP_MODE_NA4   = 2'b10,
        PMP_MODE_NAPOT = 2'b11
    } pmp_cfg_mode_e;

    typedef struct packed {
        logic          lock;
        pmp_cfg_mode_e mode;
        logic          exec;
        logic          write;
        logic          read;
    } pmp_cfg_t;

endpackage

module ibex_pmp_csr_regs #(
    parameter int unsigned PMPGranularity = 0,
    parameter int unsigned PMPNumRegions  = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                csr_req_i,
    input  logic                csr_we_i,
    input  logic [11:0]         csr_addr_i,
    input  logic [31:0]         csr_wdata_i,
    output logic                csr_gnt_o,
    output logic                csr_rvalid_o,
    output logic [31:0]         csr_rdata_o,
    output logic                csr_err_o,
    output ibex_pkg::pmp_cfg_t  csr_pmp_cfg_o [PMPNumRegions],
    output logic [33:0]         csr_pmp_addr_o [PMPNumRegions],
    output logic                pmp_cfg_updated_o
);

    import ibex_pkg::*;

    // Readback masks for coarse granularity. NAPOT reads bits [G-2:0] as
    // ones, OFF/TOR read bits [G-1:0] as zeros. Both masks collapse to zero
    // for G = 0, so the readback path needs no special case for it.
    localparam int unsigned NapotShift = (PMPGranularity >= 2) ? PMPGranularity - 1 : 0;
    localparam logic [31:0] NapotOnes  = (32'd1 << NapotShift) - 32'd1;
    localparam logic [31:0] TorZeros   = (32'd1 << PMPGranularity) - 32'd1;

    // -----------------------------------------------------------------------
    // Handshake FSM
    // -----------------------------------------------------------------------
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    state_e state_reg;
    state_e state_next;
    logic   accept;
    logic   wr_en;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        csr_gnt_o  = 1'b0;
        case (state_reg)
            IDLE: begin
                csr_gnt_o = !rst_i;
                if (csr_req_i && !rst_i) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept = csr_req_i & csr_gnt_o;
    assign wr_en  = accept & csr_we_i;

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic is_cfg;
    logic is_addr;

    assign is_cfg  = (csr_addr_i[11:4] == 8'h3A) && (csr_addr_i[3:2] == 2'b00);
    assign is_addr = (csr_addr_i[11:4] == 8'h3B);

    // -----------------------------------------------------------------------
    // Per-entry storage, WARL legalisation and lock rules
    // -----------------------------------------------------------------------
    pmp_cfg_t                   cfg_reg      [PMPNumRegions];
    pmp_cfg_t                   cfg_next     [PMPNumRegions];
    logic [31:0]                addr_reg     [PMPNumRegions];
    logic [31:0]                addr_next    [PMPNumRegions];
    logic [7:0]                 cfg_rd_entry [PMPNumRegions];
    logic [31:0]                addr_rd_entry[PMPNumRegions];
    logic [PMPNumRegions-1:0]   entry_changed;

    for (genvar gi = 0; gi < PMPNumRegions; gi++) begin : g_entry
        localparam logic [1:0] CfgIdx   = 2'(gi / 4);
        localparam int         ByteLane = gi % 4;
        localparam logic [3:0] EntryIdx = 4'(gi);

        logic [7:0] wbyte;
        pmp_cfg_t   cfg_legal;
        logic       cfg_wr;
        logic       addr_wr;
        logic       next_tor_locked;

        assign wbyte = csr_wdata_i[8*ByteLane +: 8];

        // W without R is not a legal combination: drop both. NA4 cannot be
        // expressed once the granule is wider than 4 bytes, so it falls
        // back to OFF. Bits [6:5] are simply not stored.
        always_comb begin
            cfg_legal.lock  = wbyte[7];
            cfg_legal.mode  = pmp_cfg_mode_e'(wbyte[4:3]);
            cfg_legal.exec  = wbyte[2];
            cfg_legal.write = wbyte[1] & wbyte[0];
            cfg_legal.read  = wbyte[0];
            if ((PMPGranularity >= 1) && (wbyte[4:3] == 2'b10)) begin
                cfg_legal.mode = PMP_MODE_OFF;
            end
        end

        // A locked TOR entry above uses this entry's address as its lower
        // bound, so that bound is frozen too.
        if (gi + 1 < PMPNumRegions) begin : g_has_next
            assign next_tor_locked = cfg_reg[gi+1].lock &&
                                     (cfg_reg[gi+1].mode == PMP_MODE_TOR);
        end else begin : g_no_next
            assign next_tor_locked = 1'b0;
        end

        // Lock checks look only at registered state, so a write that sets
        // L in the same transaction cannot block itself.
        assign cfg_wr  = wr_en && is_cfg && (csr_addr_i[1:0] == CfgIdx) &&
                         !cfg_reg[gi].lock;
        assign addr_wr = wr_en && is_addr && (csr_addr_i[3:0] == EntryIdx) &&
                         !cfg_reg[gi].lock && !next_tor_locked;

        assign cfg_next[gi]  = cfg_wr  ? cfg_legal   : cfg_reg[gi];
        assign addr_next[gi] = addr_wr ? csr_wdata_i : addr_reg[gi];

        assign entry_changed[gi] = (cfg_next[gi] != cfg_reg[gi]) ||
                                   (addr_next[gi] != addr_reg[gi]);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cfg_reg[gi]  <= '0;
                addr_reg[gi] <= '0;
            end else begin
                cfg_reg[gi]  <= cfg_next[gi];
                addr_reg[gi] <= addr_next[gi];
            end
        end

        assign csr_pmp_cfg_o[gi]  = cfg_reg[gi];
        assign csr_pmp_addr_o[gi] = {addr_reg[gi], 2'b00};

        // Readback views. The checker always sees the full stored address;
        // only the CSR read path applies the granularity masks.
        assign cfg_rd_entry[gi] = {cfg_reg[gi].lock, 2'b00, cfg_reg[gi].mode,
                                   cfg_reg[gi].exec, cfg_reg[gi].write,
                                   cfg_reg[gi].read};

        always_comb begin
            case (cfg_reg[gi].mode)
                PMP_MODE_NAPOT: addr_rd_entry[gi] = addr_reg[gi] | NapotOnes;
                PMP_MODE_OFF,
                PMP_MODE_TOR:   addr_rd_entry[gi] = addr_reg[gi] & ~TorZeros;
                default:        addr_rd_entry[gi] = addr_reg[gi];
            endcase
        end
    end

    // Pad to the full 16-entry CSR space so unimplemented entries read 0.
    logic [7:0]  cfg_rd_byte  [16];
    logic [31:0] addr_rd_word [16];

    for (genvar gi = 0; gi < 16; gi++) begin : g_pad
        if (gi < PMPNumRegions) begin : g_impl
            assign cfg_rd_byte[gi]  = cfg_rd_entry[gi];
            assign addr_rd_word[gi] = addr_rd_entry[gi];
        end else begin : g_unimpl
            assign cfg_rd_byte[gi]  = 8'h00;
            assign addr_rd_word[gi] = 32'h0;
        end
    end

    // -----------------------------------------------------------------------
    // Read mux and response registers
    // -----------------------------------------------------------------------
    logic [31:0] rdata_next;
    logic        err_next;
    logic [31:0] rdata_reg;
    logic        err_reg;
    logic        updated_reg;

    always_comb begin
        rdata_next = 32'h0;
        err_next   = !(is_cfg || is_addr);
        if (is_cfg) begin
            rdata_next = {cfg_rd_byte[{csr_addr_i[1:0], 2'd3}],
                          cfg_rd_byte[{csr_addr_i[1:0], 2'd2}],
                          cfg_rd_byte[{csr_addr_i[1:0], 2'd1}],
                          cfg_rd_byte[{csr_addr_i[1:0], 2'd0}]};
        end else if (is_addr) begin
            rdata_next = addr_rd_word[csr_addr_i[3:0]];
        end
    end

    // Captured on the accept edge from pre-write state; err and updated are
    // cleared on every other edge so they are single-cycle pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_reg   <= 32'h0;
            err_reg     <= 1'b0;
            updated_reg <= 1'b0;
        end else if (accept) begin
            rdata_reg   <= rdata_next;
            err_reg     <= err_next;
            updated_reg <= |entry_changed;
        end else begin
            err_reg     <= 1'b0;
            updated_reg <= 1'b0;
        end
    end

    // Gating with rst_i drops a response that is in flight when reset hits.
    assign csr_rvalid_o      = (state_reg == RESP) && !rst_i;
    assign csr_rdata_o       = rdata_reg;
    assign csr_err_o         = err_reg;
    assign pmp_cfg_updated_o = updated_reg && csr_rvalid_o;

endmodule

// File: tb/tb_ibex_pmp_csr_regs.sv
// ---------------------------------------------------------------------------
// tb_ibex_pmp_csr_regs
//
// Directed bench for ibex_pmp_csr_regs with PMPGranularity = 2 and four
// regions. Each transaction pushes its expected response (from a small
// behavioural model of the PMP CSRs) onto a scoreboard queue; a monitor pops
// and compares whenever the DUT raises rvalid.
// ---------------------------------------------------------------------------

module tb_ibex_pmp_csr_regs;

    import ibex_pkg::*;

    localparam int unsigned G = 2;
    localparam int unsigned N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        upd;
    pmp_cfg_t    cfg_o  [N];
    logic [33:0] addr_o [N];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        logic        upd;
    } exp_t;

    exp_t sb[$];

    // Behavioural model of the stored state
    logic [7:0]  cfg_m  [N];
    logic [31:0] addr_m [N];

    always #5 clk = ~clk;

    ibex_pmp_csr_regs #(
        .PMPGranularity (G),
        .PMPNumRegions  (N)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .csr_req_i         (req),
        .csr_we_i          (we),
        .csr_addr_i        (addr),
        .csr_wdata_i       (wdata),
        .csr_gnt_o         (gnt),
        .csr_rvalid_o      (rvalid),
        .csr_rdata_o       (rdata),
        .csr_err_o         (err),
        .csr_pmp_cfg_o     (cfg_o),
        .csr_pmp_addr_o    (addr_o),
        .pmp_cfg_updated_o (upd)
    );

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- model ----------------
    task automatic m_reset();
        for (int e = 0; e < N; e++) begin
            cfg_m[e]  = 8'h00;
            addr_m[e] = 32'h0;
        end
    endtask

    function automatic bit m_is_cfg(input logic [11:0] a);
        return (a[11:4] == 8'h3A) && (a[3:2] == 2'b00);
    endfunction

    function automatic bit m_is_addr(input logic [11:0] a);
        return (a[11:4] == 8'h3B);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        logic [31:0] r;
        int          e;
        r = 32'h0;
        if (m_is_cfg(a)) begin
            for (int j = 0; j < 4; j++) begin
                e = 4 * int'(a[1:0]) + j;
                if (e < N) r[8*j +: 8] = cfg_m[e];
            end
        end else if (m_is_addr(a)) begin
            e = int'(a[3:0]);
            if (e < N) begin
                r = addr_m[e];
                if (cfg_m[e][4:3] == 2'b11) r = r | ((32'd1 << (G - 1)) - 32'd1);
                else                       r = r & ~((32'd1 << G) - 32'd1);
            end
        end
        return r;
    endfunction

    task automatic m_write(input logic [11:0] a, input logic [31:0] w, output logic changed);
        logic [7:0] b;
        int         e;
        changed = 1'b0;
        if (m_is_cfg(a)) begin
            for (int j = 0; j < 4; j++) begin
                e = 4 * int'(a[1:0]) + j;
                if (e < N && !cfg_m[e][7]) begin
                    b = w[8*j +: 8];
                    b[6:5] = 2'b00;
                    if (b[1] && !b[0]) b[1] = 1'b0;
                    if (b[4:3] == 2'b10) b[4:3] = 2'b00;
                    if (b != cfg_m[e]) changed = 1'b1;
                    cfg_m[e] = b;
                end
            end
        end else if (m_is_addr(a)) begin
            e = int'(a[3:0]);
            if (e < N && !cfg_m[e][7] &&
                !(e + 1 < N && cfg_m[e+1][7] && cfg_m[e+1][4:3] == 2'b01)) begin
                if (w != addr_m[e]) changed = 1'b1;
                addr_m[e] = w;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    // Leaves req asserted on return so consecutive calls are back-to-back.
    task automatic txn(input logic w, input logic [11:0] a, input logic [31:0] d, input string tag);
        exp_t x;
        int   budget;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        budget = 0;
        while (gnt !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk({tag, "_gnt_idle"}, 34'(gnt), 34'd1);
        x.tag   = tag;
        x.rdata = m_read(a);
        x.err   = !(m_is_cfg(a) || m_is_addr(a));
        x.upd   = 1'b0;
        if (w) m_write(a, d, x.upd);
        sb.push_back(x);
        @(negedge clk);
        chk({tag, "_rvalid"}, 34'(rvalid), 34'd1);
        chk({tag, "_gnt_busy"}, 34'(gnt), 34'd0);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        exp_t x;
        if (rvalid === 1'b1) begin
            checks++;
            assert (sb.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_rvalid observed=1 expected=0");
            end
            if (sb.size() > 0) begin
                x = sb.pop_front();
                $display("txn %s rdata=0x%08h err=%b upd=%b", x.tag, rdata, err, upd);
                chk({x.tag, "_rdata"}, 34'(rdata), 34'(x.rdata));
                chk({x.tag, "_err"}, 34'(err), 34'(x.err));
                chk({x.tag, "_upd"}, 34'(upd), 34'(x.upd));
            end
        end else begin
            chk("upd_without_rvalid", 34'(upd), 34'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 12'h0; wdata = 32'h0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("reset_gnt", 34'(gnt), 34'd0);
        chk("reset_rvalid", 34'(rvalid), 34'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rdata", 34'(rdata), 34'd0);
        for (int e = 0; e < N; e++) begin
            chk("reset_cfg", {28'd0, cfg_o[e]}, 34'd0);
            chk("reset_addr", addr_o[e], 34'd0);
        end

        // Basic cfg write: entry0 TOR RWX, entry1 NAPOT RWX
        txn(1'b1, 12'h3A0, 32'h0000_1F0F, "w_cfg0_tor_napot");
        chk("cfg0_after_w", {28'd0, cfg_o[0]}, 34'b00_1111);
        chk("cfg1_mode_napot", 34'(cfg_o[1].mode), 34'd3);

        // W without R collapses to nothing
        txn(1'b1, 12'h3A0, 32'h0000_1F02, "w_cfg0_w_no_r");
        txn(1'b0, 12'h3A0, 32'h0, "r_cfg0_after_wnor");
        chk("cfg0_wnor", {28'd0, cfg_o[0]}, 34'd0);

        // Lock entry1 in TOR: pmpaddr0 becomes frozen
        txn(1'b1, 12'h3B0, 32'h0000_AAAA, "w_addr0_open");
        txn(1'b1, 12'h3A0, 32'h0000_8F00, "w_cfg0_lock1_tor");
        txn(1'b1, 12'h3B0, 32'h0000_1234, "w_addr0_blocked");
        chk("addr0_kept", addr_o[0], {32'h0000_AAAA, 2'b00});
        txn(1'b0, 12'h3B0, 32'h0, "r_addr0");
        txn(1'b1, 12'h3B1, 32'h0000_5555, "w_addr1_locked");
        txn(1'b1, 12'h3A0, 32'h0000_0000, "w_cfg0_clear_locked");
        chk("cfg1_still_locked", 34'(cfg_o[1].lock), 34'd1);

        // Illegal and unimplemented addresses
        txn(1'b1, 12'h3C0, 32'hFFFF_FFFF, "w_illegal_3c0");
        txn(1'b0, 12'h3A4, 32'h0, "r_illegal_3a4");
        txn(1'b1, 12'h3B5, 32'hFFFF_FFFF, "w_unimpl_3b5");
        txn(1'b0, 12'h3B5, 32'h0, "r_unimpl_3b5");
        txn(1'b1, 12'h3A1, 32'hFFFF_FFFF, "w_unimpl_3a1");
        txn(1'b0, 12'h3A1, 32'h0, "r_unimpl_3a1");

        // Back-to-back with req held high
        txn(1'b1, 12'h3B2, 32'h0000_0100, "b2b_w1");
        txn(1'b0, 12'h3B2, 32'h0, "b2b_r1");
        txn(1'b1, 12'h3B2, 32'h0000_0200, "b2b_w2");
        txn(1'b0, 12'h3B2, 32'h0, "b2b_r2");
        idle(2);

        // NA4 is not representable with G = 2
        txn(1'b1, 12'h3A0, 32'h0000_0017, "w_cfg0_na4");
        chk("cfg0_na4_to_off", {28'd0, cfg_o[0]}, 34'b00_0111);

        // Granularity masking on entry3 (no entry above it)
        txn(1'b1, 12'h3A0, 32'h1800_0007, "w_cfg3_napot");
        txn(1'b1, 12'h3B3, 32'h0000_0000, "w_addr3_zero");
        txn(1'b0, 12'h3B3, 32'h0, "r_addr3_napot_zero");
        txn(1'b1, 12'h3B3, 32'h0000_0012, "w_addr3_12");
        txn(1'b0, 12'h3B3, 32'h0, "r_addr3_napot_12");
        chk("addr3_full", addr_o[3], {32'h0000_0012, 2'b00});
        txn(1'b1, 12'h3A0, 32'h0800_0007, "w_cfg3_tor");
        txn(1'b0, 12'h3B3, 32'h0, "r_addr3_tor");
        chk("addr3_unchanged", addr_o[3], {32'h0000_0012, 2'b00});

        // Lock entry3 as TOR: entry2 and entry3 addresses frozen
        txn(1'b1, 12'h3A0, 32'h8800_0007, "w_cfg3_lock_tor");
        txn(1'b1, 12'h3B2, 32'h0000_0300, "w_addr2_blocked");
        txn(1'b1, 12'h3B3, 32'h0000_0044, "w_addr3_blocked");
        idle(1);

        // Reset while the response is pending: it must vanish
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 12'h3A0; wdata = 32'h0000_001F;
        chk("midrst_gnt", 34'(gnt), 34'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 1'b0;
        @(negedge clk);
        chk("midrst_rvalid_in_reset", 34'(rvalid), 34'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
        @(negedge clk);
        chk("midrst_rvalid_after", 34'(rvalid), 34'd0);
        chk("midrst_cfg0", {28'd0, cfg_o[0]}, 34'd0);
        chk("midrst_cfg1", {28'd0, cfg_o[1]}, 34'd0);
        chk("midrst_addr0", addr_o[0], 34'd0);
        chk("midrst_addr3", addr_o[3], 34'd0);
        txn(1'b0, 12'h3A0, 32'h0, "r_cfg0_post_reset");
        txn(1'b1, 12'h3B0, 32'h0000_7770, "w_addr0_post_reset");
        idle(3);

        chk("scoreboard_drained", 34'(sb.size()), 34'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
